// File: rtl/ble_rx_pkg.sv
// Shared types and constants for the BLE receive path: IQ/discriminator widths,
// preamble patterns and the demodulator state encoding.
package ble_rx_pkg;

   localparam int unsigned IQ_W   = 4;
   localparam int unsigned PROD_W = 2 * IQ_W;
   localparam int unsigned DISC_W = 9;
   localparam int unsigned PRE_W  = 8;

   localparam logic [PRE_W-1:0] PREAMBLE_A = 8'hAA;
   localparam logic [PRE_W-1:0] PREAMBLE_B = 8'h55;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACQ    = 2'd1,
      LOCKED = 2'd2
   } rx_state_e;

   // Either phase of the alternating BLE preamble is accepted.
   function automatic logic is_preamble(input logic [PRE_W-1:0] s);
      return (s == PREAMBLE_A) || (s == PREAMBLE_B);
   endfunction

endpackage

// File: rtl/ble_iq_disc.sv
// Cross-product frequency discriminator: registers the previous IQ sample and
// forms d = i_prev*q_in - q_prev*i_in combinationally against the current sample.
module ble_iq_disc
   import ble_rx_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     load,
   input  logic signed [IQ_W-1:0]   i_in,
   input  logic signed [IQ_W-1:0]   q_in,
   output logic signed [DISC_W-1:0] d_c
);

   logic signed [IQ_W-1:0]   i_prev, q_prev;
   logic signed [IQ_W-1:0]   i_eff, q_eff;
   logic signed [PROD_W-1:0] p_iq, p_qi;

   always_ff @(posedge clk) begin
      if (rst) begin
         i_prev <= '0;
         q_prev <= '0;
      end else if (load) begin
         i_prev <= i_in;
         q_prev <= q_in;
      end else if (clr) begin
         i_prev <= '0;
         q_prev <= '0;
      end
   end

   // clr forces a zero history so a sample taken on the same edge sees d = 0.
   always_comb begin
      i_eff = clr ? '0 : i_prev;
      q_eff = clr ? '0 : q_prev;
      p_iq  = PROD_W'(i_eff) * PROD_W'(q_in);
      p_qi  = PROD_W'(q_eff) * PROD_W'(i_in);
      d_c   = DISC_W'(p_iq) - DISC_W'(p_qi);
   end

endmodule

// File: rtl/ble_gfsk_demod.sv
// BLE GFSK demodulator: IQ discriminator, integrate-and-dump slicer and preamble lock.
// Define BLE_DEMOD_PREAMBLE_EN to build the ACQ/LOCKED preamble logic and drive sync.
module ble_gfsk_demod
   import ble_rx_pkg::*;
#(
   parameter int unsigned SPS      = 8,
   parameter int unsigned MAX_BITS = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              sample_valid,
   input  logic [IQ_W-1:0]   i_in,
   input  logic [IQ_W-1:0]   q_in,
   output logic              bit_out,
   output logic              bit_valid,
   output logic              sync,
   output logic [DISC_W-1:0] disc_out
);

   localparam int unsigned PH_W  = $clog2(SPS);
   localparam int unsigned ACC_W = DISC_W + PH_W;

   if (SPS < 2 || SPS > 16 || MAX_BITS < 2) begin : g_param_check
      $error("ble_gfsk_demod: SPS must be 2..16 and MAX_BITS at least 2");
   end

   rx_state_e                state_q, state_d;
   logic                     accept, start, close;
   logic [PH_W-1:0]          phase, phase_eff;
   logic signed [ACC_W-1:0]  acc, acc_eff, acc_sum;
   logic signed [DISC_W-1:0] d_c;

   assign accept = en & sample_valid;
   // Leaving IDLE with en high is the enable rising edge.
   assign start  = en & (state_q == IDLE);

   ble_iq_disc u_disc (
      .clk  (clk),
      .rst  (rst),
      .clr  (start),
      .load (accept),
      .i_in ($signed(i_in)),
      .q_in ($signed(q_in)),
      .d_c  (d_c)
   );

   always_comb begin
      phase_eff = start ? '0 : phase;
      acc_eff   = start ? '0 : acc;
      acc_sum   = acc_eff + ACC_W'(d_c);
      close     = accept && (phase_eff == PH_W'(SPS - 1));
   end

   // Integrate-and-dump over one symbol; the slice is strictly positive.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase     <= '0;
         acc       <= '0;
         bit_out   <= 1'b0;
         bit_valid <= 1'b0;
         disc_out  <= '0;
      end else begin
         bit_valid <= 1'b0;
         if (accept) begin
            disc_out <= d_c;
            if (close) begin
               bit_out   <= ~acc_sum[ACC_W-1] & (acc_sum != '0);
               bit_valid <= 1'b1;
               acc       <= '0;
               phase     <= '0;
            end else begin
               acc   <= acc_sum;
               phase <= phase_eff + PH_W'(1);
            end
         end else if (start) begin
            acc   <= '0;
            phase <= '0;
         end
      end
   end

`ifdef BLE_DEMOD_PREAMBLE_EN
   localparam int unsigned      CNT_W     = $clog2(MAX_BITS);
   localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(MAX_BITS - 1);
   localparam logic [3:0]       FILL_FULL = 4'(PRE_W);

   logic [PRE_W-1:0] sreg_q, sreg_d;
   logic [3:0]       fill_q, fill_d;
   logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
`ifdef BLE_DEMOD_PREAMBLE_EN
         sreg_q   <= '0;
         fill_q   <= '0;
         bitcnt_q <= '0;
         sync     <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
`ifdef BLE_DEMOD_PREAMBLE_EN
         sreg_q   <= sreg_d;
         fill_q   <= fill_d;
         bitcnt_q <= bitcnt_d;
         sync     <= (state_d == LOCKED);
`endif
      end
   end

`ifndef BLE_DEMOD_PREAMBLE_EN
   assign sync = 1'b0;
`endif

   // Lock decisions use the registered bit, so sync follows bit_valid by a cycle.
   always_comb begin
      state_d = state_q;
`ifdef BLE_DEMOD_PREAMBLE_EN
      sreg_d   = sreg_q;
      fill_d   = fill_q;
      bitcnt_d = bitcnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (en) begin
               state_d = ACQ;
`ifdef BLE_DEMOD_PREAMBLE_EN
               sreg_d   = '0;
               fill_d   = '0;
               bitcnt_d = '0;
`endif
            end
         end
`ifdef BLE_DEMOD_PREAMBLE_EN
         ACQ: begin
            if (bit_valid) begin
               sreg_d = {sreg_q[PRE_W-2:0], bit_out};
               fill_d = (fill_q == FILL_FULL) ? fill_q : fill_q + 4'd1;
               // Only a fully populated window may match, so zero fill cannot fake 8'h55.
               if ((fill_d == FILL_FULL) && is_preamble(sreg_d)) begin
                  state_d  = LOCKED;
                  bitcnt_d = '0;
               end
            end
         end
         LOCKED: begin
            if (bit_valid) begin
               if (bitcnt_q == LAST_BIT) begin
                  state_d = ACQ;
                  sreg_d  = '0;
                  fill_d  = '0;
               end else begin
                  bitcnt_d = bitcnt_q + CNT_W'(1);
               end
            end
         end
`else
         ACQ: state_d = ACQ;
`endif
         default: state_d = IDLE;
      endcase
      if (!en) state_d = IDLE;
   end

endmodule

// File: tb/tb_ble_gfsk_demod.sv
// Self-checking bench for ble_gfsk_demod: reference discriminator/slicer model feeds
// a queue of expected bits that is drained whenever the DUT strobes bit_valid.
`timescale 1ns/1ps
module tb_ble_gfsk_demod;

   localparam int unsigned SPS      = 8;
   localparam int unsigned MAX_BITS = 16;
`ifdef BLE_DEMOD_PREAMBLE_EN
   localparam logic PRE = 1'b1;
`else
   localparam logic PRE = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst, en, sample_valid;
   logic [3:0] i_in, q_in;
   logic       bit_out, bit_valid, sync;
   logic [8:0] disc_out;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   m_ip, m_qp, m_acc, m_phase, m_last_d;
   int   rot;
   logic exp_bits[$];

   always #5 clk = ~clk;

   ble_gfsk_demod #(.SPS(SPS), .MAX_BITS(MAX_BITS)) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .sample_valid (sample_valid),
      .i_in         (i_in),
      .q_in         (q_in),
      .bit_out      (bit_out),
      .bit_valid    (bit_valid),
      .sync         (sync),
      .disc_out     (disc_out)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   // Scoreboard drain: every strobe must match the oldest predicted bit.
   always @(negedge clk) begin
      if (bit_valid === 1'b1) begin
         if (exp_bits.size() == 0) chk("unexpected_bit_valid", 32'(bit_valid), 32'd0);
         else                      chk("bit_out", 32'(bit_out), 32'(exp_bits.pop_front()));
      end
   end

   task automatic model_clear();
      m_ip = 0; m_qp = 0; m_acc = 0; m_phase = 0;
   endtask

   task automatic drive_sample(input int si, input int sq);
      int   d;
      logic closing;
      en = 1'b1; sample_valid = 1'b1;
      i_in = 4'(si); q_in = 4'(sq);
      d       = m_ip * sq - m_qp * si;
      m_acc   = m_acc + d;
      closing = (m_phase == int'(SPS) - 1);
      if (closing) begin
         exp_bits.push_back(m_acc > 0);
         m_acc = 0; m_phase = 0;
      end else begin
         m_phase++;
      end
      m_ip = si; m_qp = sq; m_last_d = d;
      @(negedge clk);
      sample_valid = 1'b0;
      chk("disc_out", 32'($signed(disc_out)), 32'(d));
      chk("bit_valid", 32'(bit_valid), 32'(closing));
   endtask

   task automatic gap();
      sample_valid = 1'b0;
      i_in = 4'($urandom); q_in = 4'($urandom);
      @(negedge clk);
      chk("gap_bit_valid", 32'(bit_valid), 32'd0);
   endtask

   task automatic pt(input int r, output int si, output int sq);
      case (r)
         0:       begin si = 7;  sq = 0;  end
         1:       begin si = 0;  sq = 7;  end
         2:       begin si = -7; sq = 0;  end
         default: begin si = 0;  sq = -7; end
      endcase
   endtask

   task automatic send_symbol(input logic b, input logic gaps);
      int si, sq;
      for (int k = 0; k < int'(SPS); k++) begin
         pt(rot, si, sq);
         drive_sample(si, sq);
         rot = b ? (rot + 1) % 4 : (rot + 3) % 4;
         if (gaps) gap();
      end
   endtask

   task automatic enable();
      en = 1'b1;
      model_clear();
   endtask

   task automatic disable_en(input int n);
      en = 1'b0;
      for (int k = 0; k < n; k++) begin
         sample_valid = 1'b1;
         i_in = 4'($urandom); q_in = 4'($urandom);
         @(negedge clk);
         chk("idle_bit_valid", 32'(bit_valid), 32'd0);
         chk("idle_disc_hold", 32'($signed(disc_out)), 32'(m_last_d));
         chk("idle_sync", 32'(sync), 32'd0);
      end
      sample_valid = 1'b0;
   endtask

   task automatic rst_pulse();
      rst = 1'b1; sample_valid = 1'b1;
      i_in = 4'($urandom); q_in = 4'($urandom);
      @(negedge clk);
      rst = 1'b0; sample_valid = 1'b0;
      chk("rst_bit_valid", 32'(bit_valid), 32'd0);
      chk("rst_bit_out", 32'(bit_out), 32'd0);
      chk("rst_sync", 32'(sync), 32'd0);
      chk("rst_disc_out", 32'(disc_out), 32'd0);
      model_clear();
      m_last_d = 0;
   endtask

   initial begin
      int si, sq;
      rst = 1'b1; en = 1'b0; sample_valid = 1'b0;
      i_in = '0; q_in = '0; rot = 0;
      model_clear();
      m_last_d = 0;

      // Reset held with random samples, then idle with en low.
      repeat (3) begin
         sample_valid = 1'b1;
         i_in = 4'($urandom); q_in = 4'($urandom);
         @(negedge clk);
      end
      chk("reset_bit_valid", 32'(bit_valid), 32'd0);
      chk("reset_bit_out", 32'(bit_out), 32'd0);
      chk("reset_sync", 32'(sync), 32'd0);
      chk("reset_disc_out", 32'(disc_out), 32'd0);
      rst = 1'b0;
      disable_en(4);

      // Positive rotation: 49 per sample, slices to 1.
      enable(); rot = 0;
      send_symbol(1'b1, 1'b0);
      send_symbol(1'b1, 1'b0);
      disable_en(3);

      // Negative rotation: -49 per sample, slices to 0.
      enable(); rot = 0;
      repeat (3) send_symbol(1'b0, 1'b0);
      disable_en(2);

      // Preamble 10101010, then MAX_BITS locked bits.
      enable(); rot = 0;
      for (int i = 0; i < 8; i++) begin
         send_symbol((i % 2) == 0, 1'b0);
         chk("sync_before_lock", 32'(sync), 32'd0);
      end
      gap();
      chk("sync_lock", 32'(sync), 32'(PRE));
      for (int i = 8; i < 8 + int'(MAX_BITS); i++) begin
         send_symbol((i % 2) == 0, 1'b0);
         chk("sync_locked", 32'(sync), 32'(PRE));
      end
      gap();
      chk("sync_unlock", 32'(sync), 32'd0);
      disable_en(2);

      // Gapped input must slice exactly as gapless input.
      enable(); rot = 0;
      send_symbol(1'b1, 1'b1);
      send_symbol(1'b0, 1'b1);
      send_symbol(1'b1, 1'b1);

      // Abort mid-symbol: partial integration is dropped, realigned after reset.
      for (int k = 0; k < 4; k++) begin
         pt(rot, si, sq);
         drive_sample(si, sq);
         rot = (rot + 1) % 4;
      end
      rst_pulse();
      send_symbol(1'b1, 1'b0);
      send_symbol(1'b0, 1'b0);
      disable_en(2);

      // Random IQ, then an all-zero symbol whose sum of 0 must slice to 0.
      enable();
      for (int k = 0; k < 4 * int'(SPS); k++) begin
         drive_sample(int'($urandom_range(15, 0)) - 8, int'($urandom_range(15, 0)) - 8);
      end
      for (int k = 0; k < int'(SPS); k++) drive_sample(0, 0);

      repeat (3) gap();
      chk("pending_bits", 32'(exp_bits.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
